// File: rtl/ram_load_controller_pkg.sv
// Shared types and default widths for the RAM load controller and its neighbours.
package ram_load_controller_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_VERIFY  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

endpackage

// File: rtl/ram_load_controller_port_mux.sv
// Combinational RAM-port select: the CPU drives the RAM unless the controller owns it.
module ram_load_controller_port_mux
  import ram_load_controller_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_ctrl_own,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  input  logic              i_ctrl_we,
  input  logic [ADDR_W-1:0] i_ctrl_addr,
  input  logic [DATA_W-1:0] i_ctrl_wdata,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata
);

  // When the controller owns the port the CPU write enable is dropped entirely.
  always_comb begin
    if (i_ctrl_own) begin
      o_ram_we    = i_ctrl_we;
      o_ram_addr  = i_ctrl_addr;
      o_ram_wdata = i_ctrl_wdata;
    end else begin
      o_ram_we    = i_cpu_we;
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
    end
  end

endmodule

// File: rtl/ram_load_controller.sv
// RAM load controller: freezes the CPU, streams a program image into RAM,
// reads it back to verify the checksum, then pulses CPU reset and releases the port.
//
// Host handshake: a byte transfers on a rising fastClk edge where in_valid and
// in_ready are both high; the host holds in_data stable while in_valid is high
// and not yet accepted; in_ready never depends on in_valid.
module ram_load_controller
  import ram_load_controller_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = 16,
  parameter int RST_CYC = 2
) (
  input  logic              fastClk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_hold,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum,
  output logic [2:0]        dbg_state
);

  // Counters carry one extra bit so a full 2**ADDR_W load ends without wrapping.
  localparam int CNT_W = ADDR_W + 1;
  localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t            r_state;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [DATA_W-1:0] r_vsum;
  logic [DATA_W-1:0] r_checksum;
  logic [RC_W-1:0]   r_rst_cnt;
  logic              r_in_ready;
  logic              r_cpu_hold;
  logic              r_cpu_rst;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_ctrl_own;
  logic [ADDR_W-1:0] w_ctrl_addr;
  logic [DATA_W-1:0] w_vsum_next;

  assign w_accept    = (r_state == ST_WRITE) && r_in_ready && in_valid;
  assign w_ctrl_own  = !((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_ctrl_addr = (r_state == ST_VERIFY) ? r_rd_cnt[ADDR_W-1:0] : r_wr_cnt[ADDR_W-1:0];
  assign w_vsum_next = r_vsum + ram_rdata;

  ram_load_controller_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .i_ctrl_own   (w_ctrl_own),
    .i_cpu_we     (cpu_we),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_ctrl_we    (w_accept),
    .i_ctrl_addr  (w_ctrl_addr),
    .i_ctrl_wdata (in_data),
    .o_ram_we     (ram_we),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata)
  );

  // Load sequencer: state, counters, checksum and registered status flags.
  always_ff @(posedge fastClk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_vsum     <= '0;
      r_checksum <= '0;
      r_rst_cnt  <= '0;
      r_in_ready <= 1'b0;
      r_cpu_hold <= 1'b0;
      r_cpu_rst  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_FAULT: begin
          // A simultaneous abort suppresses the start request.
          if (load_start && !load_abort) begin
            r_state    <= ST_WRITE;
            r_wr_cnt   <= '0;
            r_checksum <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cpu_hold <= 1'b1;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        ST_WRITE: begin
          // An accepted byte always counts, even when it arrives with an abort.
          if (w_accept) begin
            r_checksum <= r_checksum + in_data;
            r_wr_cnt   <= r_wr_cnt + 1'b1;
          end
          if (load_abort) begin
            r_state    <= ST_FAULT;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_in_ready <= 1'b0;
          end else if (w_accept && (r_wr_cnt == CNT_W'(DEPTH - 1))) begin
            r_state    <= ST_VERIFY;
            r_rd_cnt   <= '0;
            r_vsum     <= '0;
            r_in_ready <= 1'b0;
          end
        end
        ST_VERIFY: begin
          // Read data lags the address by one cycle, so summing starts at rd_cnt=1.
          if (r_rd_cnt != '0) begin
            r_vsum <= w_vsum_next;
          end
          if (r_rd_cnt != CNT_W'(DEPTH)) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
          if (load_abort) begin
            r_state <= ST_FAULT;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_rd_cnt == CNT_W'(DEPTH)) begin
            if (w_vsum_next == r_checksum) begin
              r_state   <= ST_RELEASE;
              r_cpu_rst <= 1'b1;
              r_rst_cnt <= '0;
            end else begin
              r_state <= ST_FAULT;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_RELEASE: begin
          if (r_rst_cnt == RC_W'(RST_CYC - 1)) begin
            r_state    <= ST_DONE;
            r_cpu_rst  <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign cpu_rdata = ram_rdata;
  assign cpu_hold  = r_cpu_hold;
  assign cpu_rst   = r_cpu_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign checksum  = r_checksum;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_load_controller.sv
// Bench for ram_load_controller: host loader driver, RAM model, write scoreboard.
module tb_ram_load_controller;
  import ram_load_controller_pkg::*;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              fastClk;
  logic              rst;
  logic              load_start;
  logic              load_abort;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              cpu_hold;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] checksum;
  logic [2:0]        dbg_state;

  int checks;
  int failures;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  logic [DATA_W-1:0] mem [DEPTH];
  logic              corrupt5;
  logic              rst_seen;

  ram_load_controller #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .DEPTH (DEPTH), .RST_CYC (2)
  ) dut (
    .fastClk    (fastClk),
    .rst        (rst),
    .load_start (load_start),
    .load_abort (load_abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .cpu_hold   (cpu_hold),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial fastClk = 1'b0;
  always #5 fastClk = ~fastClk;

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model (1-cycle read latency, optional fault at addr 5) ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ram_rdata = '0;
  end

  always @(posedge fastClk) begin
    ram_rdata <= mem[ram_addr] + ((corrupt5 && ram_addr == 4'd5) ? 8'd1 : 8'd0);
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  // ---------------- monitor: every RAM write must match the next expected one ----------------
  always @(negedge fastClk) begin
    if (cpu_rst) rst_seen = 1'b1;
    if (ram_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write", ram_addr, ram_wdata);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        if ({ram_addr, ram_wdata} !== e) begin
          failures++;
          $display("FAIL ram_write actual=%03h required=%03h", {ram_addr, ram_wdata}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge fastClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_load;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  // Streams bytes 1..n to addresses 0..n-1; abort_at marks the byte carrying load_abort.
  task automatic send_bytes(input int n, input bit gaps, input int abort_at);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      in_valid   = 1'b1;
      in_data    = 8'(i + 1);
      load_abort = (i + 1 == abort_at);
      exp_q.push_back({4'(i), 8'(i + 1)});
      guard = 0;
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) chk("in_ready_timeout", 32'(guard), 0);
      tick();
    end
    in_valid   = 1'b0;
    load_abort = 1'b0;
  endtask

  // Counts cycles until cpu_rst rises (bounded).
  task automatic wait_cpu_rst(output int n);
    n = 0;
    while (!cpu_rst && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_image(input string tag);
    for (int i = 0; i < DEPTH; i++) chk(tag, 32'(mem[i]), 32'(i + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1'b1; load_start = 0; load_abort = 0; in_valid = 0; in_data = '0;
    cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; corrupt5 = 0; rst_seen = 0;
    repeat (3) tick();
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_flags", {in_ready, ram_we, cpu_hold, cpu_rst, busy, done, err}, 0);
    chk("reset_checksum", 32'(checksum), 0);
    rst = 1'b0;
    tick();

    // Nominal load, CPU hammering writes throughout
    start_load();
    chk("start_flags", {cpu_hold, busy, in_ready, done, err}, 5'b11100);
    cpu_we = 1'b1; cpu_addr = 4'd9; cpu_wdata = 8'h55;
    send_bytes(DEPTH, 1'b0, 0);
    chk("nom_checksum", 32'(checksum), 32'h88);
    chk("nom_ready_drop", 32'(in_ready), 0);
    wait_cpu_rst(n);
    chk("nom_verify_latency", 32'(n), 17);
    cpu_we = 1'b0;
    n = 0;
    while (cpu_rst && n < 20) begin tick(); n++; end
    chk("nom_rst_pulse_len", 32'(n), 2);
    chk("nom_done_flags", {done, err, cpu_hold, busy}, 4'b1000);
    check_image("nom_image");

    // CPU owns the port in DONE
    cpu_we = 1'b1; cpu_addr = 4'd3; cpu_wdata = 8'hAA;
    exp_q.push_back({4'd3, 8'hAA});
    #1;
    chk("done_cpu_port", {ram_we, ram_addr, ram_wdata}, {1'b1, 4'd3, 8'hAA});
    tick();
    cpu_we = 1'b0;
    tick(); tick();
    chk("done_cpu_rdata", 32'(cpu_rdata), 32'hAA);

    // Backpressure gaps
    start_load();
    chk("gap_done_cleared", 32'(done), 0);
    send_bytes(DEPTH, 1'b1, 0);
    chk("gap_checksum", 32'(checksum), 32'h88);
    wait_cpu_rst(n);
    repeat (3) tick();
    chk("gap_done", {done, err, cpu_hold}, 3'b100);
    check_image("gap_image");

    // Verify failure via corrupted readback at address 5
    corrupt5 = 1'b1; rst_seen = 1'b0;
    start_load();
    send_bytes(DEPTH, 1'b0, 0);
    repeat (17) tick();
    chk("vfail_state", 32'(dbg_state), 32'(ST_FAULT));
    chk("vfail_flags", {err, done, cpu_hold, busy}, 4'b1010);
    cpu_we = 1'b1; cpu_addr = 4'd2; cpu_wdata = 8'h11;
    repeat (3) tick();
    chk("vfail_no_cpu_write", 32'(ram_we), 0);
    chk("vfail_hold_kept", 32'(cpu_hold), 1);
    chk("vfail_no_cpu_rst", 32'(rst_seen), 0);
    cpu_we = 1'b0; corrupt5 = 1'b0;

    // Abort together with the 7th byte
    start_load();
    send_bytes(7, 1'b0, 7);
    chk("abort_state", 32'(dbg_state), 32'(ST_FAULT));
    chk("abort_flags", {err, done, busy, in_ready, cpu_hold}, 5'b10001);
    chk("abort_checksum", 32'(checksum), 32'h1C);
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) begin
      #1;
      chk("abort_no_write", 32'(ram_we), 0);
      tick();
    end
    in_valid = 1'b0;

    // Reset in the middle of VERIFY, then a clean reload
    start_load();
    send_bytes(DEPTH, 1'b0, 0);
    repeat (8) tick();
    chk("midv_state", 32'(dbg_state), 32'(ST_VERIFY));
    rst = 1'b1;
    tick();
    chk("midv_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("midv_rst_flags", {in_ready, ram_we, cpu_hold, cpu_rst, busy, done, err}, 0);
    chk("midv_rst_checksum", 32'(checksum), 0);
    rst = 1'b0;
    tick();
    start_load();
    send_bytes(DEPTH, 1'b0, 0);
    wait_cpu_rst(n);
    chk("reload_latency", 32'(n), 17);
    repeat (3) tick();
    chk("reload_done", {done, err, cpu_hold, busy}, 4'b1000);
    chk("reload_checksum", 32'(checksum), 32'h88);

    repeat (2) tick();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
